ping_scheduler: RTL and testbench

- Time-multiplexes firing of the ultrasonic ping front-ends so only one transducer is active at a time, which prevents cross-echo between the side-back, side-front and front sensors.
- Walks enabled sensors round-robin: start pulse, wait for echo-done or timeout, silent guard interval, next sensor.
- Latches each sensor's distance into a per-sensor output register with valid/timeout flags.
- Sits between the ping instances and the debounce/orientation path in the ultrasonic subsystem.

---
 rtl/us_pkg.sv | 27 ++
 rtl/rr_next_index.sv | 33 +++
 rtl/ping_scheduler.sv | 129 ++++++++++++
 tb/tb_ping_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_pkg.sv
// Shared definitions for the ultrasonic subsystem.
// Includes the scheduler state encoding, default 50 MHz timing and sensor indices.
package us_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_FIRE,
      ST_WAIT_ECHO,
      ST_GUARD
   } state_t;

   localparam int CLK_HZ                 = 50_000_000;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1_250_000;
   localparam int DEFAULT_GUARD_CYCLES   = 500_000;
   localparam int DEFAULT_DIST_W         = 8;

   localparam int SIDE_BACK  = 0;
   localparam int SIDE_FRONT = 1;
   localparam int FRONT      = 2;
   localparam int BACK       = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_next_index.sv
// Round-robin finder: returns the first set mask bit at or after from_idx.
// The search wraps modulo NUM_SENSORS.
module rr_next_index #(
   parameter int NUM_SENSORS = 3,
   parameter int IDX_W       = 2
) (
   input  logic [NUM_SENSORS-1:0] mask,
   input  logic [IDX_W-1:0]       from_idx,
   output logic [IDX_W-1:0]       next_idx,
   output logic                   found
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Scan from the farthest offset down, so the nearest set bit is written last.
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
         cand = int'(from_idx) + k;
         if (cand >= NUM_SENSORS) cand = cand - NUM_SENSORS;
         cand_idx = IDX_W'(cand);
         if (mask[cand_idx]) begin
            next_idx = cand_idx;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ping_scheduler.sv
// Round-robin ultrasonic ping scheduler.
// Only one transducer is fired at a time, and each result is latched per sensor.
module ping_scheduler
   import us_pkg::*;
#(
   parameter int NUM_SENSORS    = 3,
   parameter int DIST_W         = DEFAULT_DIST_W,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int GUARD_CYCLES   = DEFAULT_GUARD_CYCLES,
   parameter logic [DIST_W-1:0] TIMEOUT_DIST = '1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_SENSORS-1:0]        sensor_mask,
   output logic [NUM_SENSORS-1:0]        start,
   input  logic [NUM_SENSORS-1:0]        done,
   input  logic [NUM_SENSORS*DIST_W-1:0] dist_in,
   output logic [NUM_SENSORS*DIST_W-1:0] dist_out,
   output logic [NUM_SENSORS-1:0]        valid,
   output logic [NUM_SENSORS-1:0]        timed_out,
   output logic [$clog2(NUM_SENSORS)-1:0] active_id,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int IDX_W   = $clog2(NUM_SENSORS);
   localparam int CNT_MAX = max_int(TIMEOUT_CYCLES, GUARD_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_SENSORS - 1);

   state_t                 state;
   logic [IDX_W-1:0]       ptr;
   logic [NUM_SENSORS-1:0] mask_q;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_found;
   logic [IDX_W-1:0]       top_idx;

   rr_next_index #(
      .NUM_SENSORS (NUM_SENSORS),
      .IDX_W       (IDX_W)
   ) u_rr_next_index (
      .mask     (sensor_mask),
      .from_idx (ptr),
      .next_idx (sel_idx),
      .found    (sel_found)
   );

   // The frame boundary is the highest sensor of the mask captured at SELECT.
   always_comb begin
      top_idx = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (mask_q[i]) top_idx = IDX_W'(i);
      end
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         mask_q     <= '0;
         cnt        <= '0;
         start      <= '0;
         dist_out   <= '0;
         valid      <= '0;
         timed_out  <= '0;
         active_id  <= '0;
         frame_done <= 1'b0;
      end else begin
         start      <= '0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && (|sensor_mask)) state <= ST_SELECT;
            end
            ST_SELECT: begin
               if (sel_found) begin
                  ptr            <= sel_idx;
                  active_id      <= sel_idx;
                  mask_q         <= sensor_mask;
                  start[sel_idx] <= 1'b1;
                  state          <= ST_FIRE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_FIRE: begin
               cnt   <= '0;
               state <= ST_WAIT_ECHO;
            end
            // An echo arriving on the final timeout cycle still counts as a real result.
            ST_WAIT_ECHO: begin
               if (done[active_id]) begin
                  dist_out[active_id*DIST_W +: DIST_W] <= dist_in[active_id*DIST_W +: DIST_W];
                  valid[active_id]     <= 1'b1;
                  timed_out[active_id] <= 1'b0;
                  cnt                  <= '0;
                  state                <= ST_GUARD;
               end else if (cnt == TIMEOUT_LAST) begin
                  dist_out[active_id*DIST_W +: DIST_W] <= TIMEOUT_DIST;
                  valid[active_id]     <= 1'b1;
                  timed_out[active_id] <= 1'b1;
                  cnt                  <= '0;
                  state                <= ST_GUARD;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GUARD: begin
               if (cnt == GUARD_LAST) begin
                  frame_done <= (ptr == top_idx);
                  ptr        <= (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
                  state      <= (enable && (|sensor_mask)) ? ST_SELECT : ST_IDLE;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler.
// A cycle-level schedule model predicts every output from the rotation rules.
module tb_ping_scheduler;

   localparam int N = 3;
   localparam int T = 20;
   localparam int G = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [N-1:0]  sensor_mask;
   logic [N-1:0]  start;
   logic [N-1:0]  done;
   logic [N*8-1:0] dist_in;
   logic [N*8-1:0] dist_out;
   logic [N-1:0]  valid;
   logic [N-1:0]  timed_out;
   logic [1:0]    active_id;
   logic          busy;
   logic          frame_done;

   int testsRun = 0;
   int testsFailed = 0;

   int             ptrM;
   bit             pendFrame;
   logic [N-1:0]   expStart;
   logic [N*8-1:0] expDist;
   logic [N-1:0]   expValid;
   logic [N-1:0]   expTo;
   logic [1:0]     expActive;
   logic           expBusy;
   logic           expFrame;

   ping_scheduler #(
      .NUM_SENSORS    (N),
      .DIST_W         (8),
      .TIMEOUT_CYCLES (T),
      .GUARD_CYCLES   (G),
      .TIMEOUT_DIST   (8'hFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sensor_mask (sensor_mask),
      .start       (start),
      .done        (done),
      .dist_in     (dist_in),
      .dist_out    (dist_out),
      .valid       (valid),
      .timed_out   (timed_out),
      .active_id   (active_id),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int nextSensor(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[2'((p + k) % N)]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int highestBit(input logic [N-1:0] m);
      int h = -1;
      for (int k = 0; k < N; k++) begin
         if (m[2'(k)]) h = k;
      end
      return h;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".start"},      32'(start),      32'(expStart));
      checkVal({tag, ".frame_done"}, 32'(frame_done), 32'(expFrame));
      checkVal({tag, ".busy"},       32'(busy),       32'(expBusy));
      checkVal({tag, ".active_id"},  32'(active_id),  32'(expActive));
      checkVal({tag, ".dist_out"},   32'(dist_out),   32'(expDist));
      checkVal({tag, ".valid"},      32'(valid),      32'(expValid));
      checkVal({tag, ".timed_out"},  32'(timed_out),  32'(expTo));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearModel();
      ptrM      = 0;
      pendFrame = 1'b0;
      expStart  = '0;
      expDist   = '0;
      expValid  = '0;
      expTo     = '0;
      expActive = '0;
      expBusy   = 1'b0;
      expFrame  = 1'b0;
   endtask

   task automatic idleTicks(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         expFrame  = pendFrame;
         pendFrame = 1'b0;
         expBusy   = 1'b0;
         expStart  = '0;
         checkOutput("idle");
         expFrame = 1'b0;
      end
   endtask

   // One complete ping: d is the WAIT cycle carrying DONE (0 = never answers).
   task automatic applyStimulus(input int d, input int spur, input bit fireDone,
                                input int dropAt, input int resetAt);
      int  s;
      int  e;
      bit  hit;
      bit  lastInFrame;
      s           = nextSensor(sensor_mask, ptrM);
      lastInFrame = (s == highestBit(sensor_mask));
      hit         = (d >= 1) && (d <= T);
      e           = hit ? d : T;

      tick();
      expFrame  = pendFrame;
      pendFrame = 1'b0;
      expBusy   = 1'b1;
      expStart  = '0;
      checkOutput("select");
      expFrame = 1'b0;

      tick();
      expStart  = N'(1 << s);
      expActive = 2'(s);
      checkOutput("fire");
      done = '0;
      if (fireDone) done[s] = 1'b1;
      expStart = '0;

      for (int k = 1; k <= e; k++) begin
         tick();
         checkOutput("wait");
         done = '0;
         if (k == d) done[s] = 1'b1;
         if (spur >= 0 && k == 3) done[spur] = 1'b1;
         if (k == dropAt) enable = 1'b0;
         if (k == resetAt) begin
            reset = 1'b1;
            tick();
            clearModel();
            checkOutput("reset_mid");
            tick();
            checkOutput("reset_hold");
            done   = '0;
            enable = 1'b0;
            reset  = 1'b0;
            return;
         end
      end

      tick();
      done = '0;
      expDist[s*8 +: 8] = hit ? dist_in[s*8 +: 8] : 8'hFF;
      expValid[s] = 1'b1;
      expTo[s]    = !hit;
      checkOutput("latch");
      for (int g = 2; g <= G; g++) begin
         tick();
         checkOutput("guard");
      end
      pendFrame = lastInFrame;
      ptrM      = (s + 1) % N;
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      sensor_mask = '0;
      done        = '0;
      dist_in     = '0;
      clearModel();
      tick();
      tick();
      tick();
      checkOutput("reset");
      reset = 1'b0;
      idleTicks(2);

      // All three sensors answer after 4 cycles.
      $display("[TB] full rotation with echoes");
      enable      = 1'b1;
      sensor_mask = 3'b111;
      dist_in     = {8'h30, 8'h20, 8'h10};
      applyStimulus(4, -1, 1'b0, 0, 0);
      applyStimulus(4, -1, 1'b0, 0, 0);
      applyStimulus(4, -1, 1'b0, 0, 0);
      checkVal("rotation.dist_out", 32'(dist_out), 32'h302010);
      checkVal("rotation.valid", 32'(valid), 32'h7);
      applyStimulus(4, -1, 1'b0, 0, 0);

      // Sensor 1 stays silent and times out.
      $display("[TB] timeout on sensor 1");
      dist_in = {8'h33, 8'h22, 8'h11};
      applyStimulus(0, -1, 1'b0, 0, 0);
      checkVal("timeout.timed_out", 32'(timed_out), 32'h2);
      checkVal("timeout.slice1", 32'(dist_out[15:8]), 32'hFF);
      applyStimulus(4, -1, 1'b0, 0, 0);

      // Sensor 1 masked off: rotation alternates 0 and 2.
      $display("[TB] mask 101");
      sensor_mask = 3'b101;
      for (int i = 0; i < 4; i++) begin
         dist_in = 24'($urandom());
         applyStimulus($urandom_range(1, T), -1, 1'b0, 0, 0);
      end
      checkVal("mask101.slice1", 32'(dist_out[15:8]), 32'hFF);

      // DONE in FIRE and a spurious DONE are ignored; DONE on the timeout cycle wins.
      $display("[TB] spurious and boundary DONE");
      sensor_mask = 3'b111;
      dist_in     = {8'h5A, 8'h4B, 8'h3C};
      applyStimulus(T, 2, 1'b1, 0, 0);
      checkVal("boundary.slice0", 32'(dist_out[7:0]), 32'h3C);
      checkVal("boundary.to0", 32'(timed_out[0]), 32'h0);

      $display("[TB] randomized rotations");
      for (int i = 0; i < 8; i++) begin
         sensor_mask = N'($urandom_range(1, 7));
         dist_in     = 24'($urandom());
         applyStimulus($urandom_range(0, T), -1, 1'b0, 0, 0);
      end

      // Drop ENABLE two cycles after sensor 1 fires.
      $display("[TB] enable drop");
      sensor_mask = 3'b111;
      while (nextSensor(sensor_mask, ptrM) != 1) begin
         dist_in = 24'($urandom());
         applyStimulus(4, -1, 1'b0, 0, 0);
      end
      dist_in = {8'h77, 8'h66, 8'h55};
      applyStimulus(6, -1, 1'b0, 2, 0);
      idleTicks(8);
      checkVal("drop.slice1", 32'(dist_out[15:8]), 32'h66);

      $display("[TB] reset during WAIT_ECHO");
      enable = 1'b1;
      applyStimulus(0, -1, 1'b0, 0, 5);
      idleTicks(5);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
